cpri_chip_unpack: RTL and testbench
===================================

# cpri_chip_unpack

Downstream stage of the per-antenna CPRI receive buffer. Consumes its 96-word chips (64-bit word, 7-bit word index 0..95, last flag), checks chip framing, and stores complete chips in a two-bank ping-pong buffer. It replays each committed chip as a 192-sample stream of 32-bit IQ samples with valid/ready backpressure toward the dimension-reduction datapath. Malformed chips and chips arriving with both banks occupied are dropped and counted.

## Interface
- DATA_WIDTH, 64, input word width; always 2×SAMPLE_WIDTH
- SAMPLE_WIDTH, 32, output IQ sample width (I in [31:16], Q in [15:0])
- CHIP_WORDS, 96, words per chip; index range 0..CHIP_WORDS-1
- CNT_WIDTH, 16, error counter width

- i_clk  in  1  clock; all logic in this domain
- i_reset  in  1  reset: i_reset, synchronous, active-high; clock i_clk
- i_data  in  DATA_WIDTH  chip word
- i_addr  in  7  word index within chip
- i_last  in  1  marks word CHIP_WORDS-1
- i_valid  in  1  word qualifier; no backpressure toward source
- o_iq  out  SAMPLE_WIDTH  output sample
- o_idx  out  8  sample index 0..191
- o_sop  out  1  high with o_idx==0
- o_eop  out  1  high with o_idx==191
- o_valid  out  1  sample qualifier
- i_ready  in  1  sink accepts when o_valid&i_ready
- o_bank_full  out  2  per-bank committed flag
- o_frm_err_cnt  out  CNT_WIDTH  framing-error chip count, saturating
- o_ovf_cnt  out  CNT_WIDTH  overflow-drop chip count, saturating

## Operation
- Write FSM: W_IDLE, W_FILL, W_DROP.
- W_IDLE: valid word with i_addr==0 and a free bank → write word 0 to that bank, go W_FILL. Free bank choice: bank wr_sel (toggles after each commit) if free, else the other one. Addr 0 with no free bank → o_ovf_cnt+1, go W_DROP. Valid word with i_addr≠0 → ignored, no count (idle garbage).
- W_FILL: expected index exp increments per valid word. Valid word with i_addr==exp writes. At exp==CHIP_WORDS-1 with i_last=1 → commit: set o_bank_full[bank], toggle wr_sel, go W_IDLE. Any mismatch (i_addr≠exp, i_last at wrong index, or i_last missing on index 95) → o_frm_err_cnt+1, bank stays free, go W_DROP; if the offending word has i_addr==0 and a bank is free, instead restart the fill at word 0 (still counting the error).
- W_DROP: discard words until a valid i_last word, then W_IDLE. A valid i_addr==0 word in W_DROP is treated as in W_IDLE.
- Read FSM: R_IDLE, R_RUN. R_IDLE: if a bank is full (oldest first, tracked by rd_sel) → R_RUN. R_RUN emits 192 samples: sample 2k = word k [31:0], sample 2k+1 = word k [63:32].
- After the o_eop sample is accepted: clear o_bank_full[rd_sel], toggle rd_sel, return to R_IDLE; if the other bank is already full, start it with no bubble.
- Output: o_valid/o_iq/o_idx/o_sop/o_eop hold stable while o_valid&!i_ready. o_valid never drops mid-chip.
- Counters saturate at all-ones.

## Timing
- Reset: all outputs 0, o_bank_full=0, FSMs idle, wr_sel=rd_sel=0, counters 0. Partial chips discard, and an in-progress readout aborts at the next edge.
- Memory read is registered (1 cycle). A 2-entry output skid keeps 1 sample/cycle throughput while i_ready=1.
- Commit: o_bank_full bit rises the cycle after the last word's edge. The first o_valid follows 2 cycles after that (read idle).
- Bank release takes effect the cycle after eop acceptance. Addr 0 arriving the same cycle as eop acceptance sees the bank busy.
- Input rate up to 1 word/cycle. Readout needs 192 cycles per chip, so sustained back-to-back chips overflow by design.

## Test plan
- Single chip, words 0..95 (word k = {32'h1000+2k+1, 32'h1000+2k}), i_ready=1 → 192 contiguous samples 0x1000..0x10BF, o_sop at idx 0, o_eop at idx 191, o_bank_full back to 0, counters 0.
- Three chips back-to-back, i_ready=1 → chips 1,2 output in order. Chip 3 is dropped: o_ovf_cnt=1.
- Chip with word 40 missing (addr jumps 39→41) → o_frm_err_cnt=1, no output. Next clean chip outputs normally.
- i_ready toggled 1/0 every cycle during readout → 192 samples, values and indices unchanged, o_iq stable while stalled.
- i_reset pulsed at sample 100 of readout while the second bank is full → next cycle o_valid=0, o_bank_full=0. A new chip after reset outputs from idx 0.
- Counter saturation with CNT_WIDTH=2: 5 malformed chips → o_frm_err_cnt=3.

Source files
------------

// File: rtl/cpri_chip_unpack.sv
// Frames 96-word CPRI chips into a two-bank ping-pong buffer and replays each
// committed chip as a 192-sample IQ stream with valid/ready backpressure.
module cpri_chip_unpack #(
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned SAMPLE_WIDTH = 32,
   parameter int unsigned CHIP_WORDS   = 96,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [DATA_WIDTH-1:0]   i_data,
   input  logic [6:0]              i_addr,
   input  logic                    i_last,
   input  logic                    i_valid,
   output logic [SAMPLE_WIDTH-1:0] o_iq,
   output logic [7:0]              o_idx,
   output logic                    o_sop,
   output logic                    o_eop,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [1:0]              o_bank_full,
   output logic [CNT_WIDTH-1:0]    o_frm_err_cnt,
   output logic [CNT_WIDTH-1:0]    o_ovf_cnt
);
   localparam logic [6:0] LAST_WORD = 7'(CHIP_WORDS - 1);
   localparam logic [7:0] LAST_SMP  = 8'(2 * CHIP_WORDS - 1);

   typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
   typedef enum logic {R_IDLE, R_RUN} rstate_t;

   logic [DATA_WIDTH-1:0] mem [2][CHIP_WORDS];

   wstate_t wstate, wstate_n;
   logic    wbank, wbank_n, wr_sel;
   logic [6:0] exp_idx, exp_idx_n;
   logic    wr_en_c, wr_bank_c, commit_c, frm_err_c, ovf_c;
   logic    free_c, pick_c, start_c;

   rstate_t rstate, rstate_n;
   logic [7:0] iss_cnt, iss_cnt_n;
   logic    iss_sel, iss_sel_n, rd_sel;
   logic    issue_c, room_c, pop_c;
   logic [1:0] occ_c;

   logic [DATA_WIDTH-1:0]   rd_word;
   logic                    p_v;
   logic [7:0]              p_idx;
   logic [SAMPLE_WIDTH-1:0] p_iq_c;
   logic                    s_v;
   logic [SAMPLE_WIDTH-1:0] s_iq;
   logic [7:0]              s_idx;

   // Write side: chip framing check and bank selection
   always_comb begin
      wstate_n  = wstate;
      wbank_n   = wbank;
      exp_idx_n = exp_idx;
      wr_en_c   = 1'b0;
      wr_bank_c = wbank;
      commit_c  = 1'b0;
      frm_err_c = 1'b0;
      ovf_c     = 1'b0;
      start_c   = 1'b0;
      free_c    = ~&o_bank_full;
      pick_c    = o_bank_full[wr_sel] ? ~wr_sel : wr_sel;
      if (i_valid) begin
         case (wstate)
            W_FILL: begin
               if (i_addr == exp_idx && i_last == (exp_idx == LAST_WORD)) begin
                  wr_en_c = 1'b1;
                  if (i_last) begin
                     commit_c = 1'b1;
                     wstate_n = W_IDLE;
                  end else begin
                     exp_idx_n = exp_idx + 7'd1;
                  end
               end else begin
                  frm_err_c = 1'b1;
                  if (i_addr == 7'd0 && free_c) start_c = 1'b1;
                  else                          wstate_n = W_DROP;
               end
            end
            default: begin
               if (i_addr == 7'd0) begin
                  if (free_c) begin
                     start_c = 1'b1;
                  end else begin
                     ovf_c    = 1'b1;
                     wstate_n = W_DROP;
                  end
               end else if (wstate == W_DROP && i_last) begin
                  wstate_n = W_IDLE;
               end
            end
         endcase
         if (start_c) begin
            wr_en_c   = 1'b1;
            wr_bank_c = pick_c;
            wbank_n   = pick_c;
            exp_idx_n = 7'd1;
            wstate_n  = W_FILL;
         end
      end
   end

   // Read side: issue one memory read per sample while the skid has room
   always_comb begin
      rstate_n  = rstate;
      iss_cnt_n = iss_cnt;
      iss_sel_n = iss_sel;
      pop_c     = o_valid & i_ready;
      occ_c     = {1'b0, o_valid} + {1'b0, s_v} + {1'b0, p_v};
      room_c    = (occ_c < 2'd2) || (pop_c && occ_c == 2'd2);
      case (rstate)
         R_IDLE:  issue_c = o_bank_full[iss_sel] && room_c;
         default: issue_c = room_c;
      endcase
      if (issue_c) begin
         if (iss_cnt == LAST_SMP) begin
            iss_cnt_n = 8'd0;
            iss_sel_n = ~iss_sel;
            rstate_n  = R_IDLE;
         end else begin
            iss_cnt_n = iss_cnt + 8'd1;
            rstate_n  = R_RUN;
         end
      end
   end

   assign p_iq_c = p_idx[0] ? rd_word[DATA_WIDTH-1:SAMPLE_WIDTH] : rd_word[SAMPLE_WIDTH-1:0];

   always_ff @(posedge i_clk) begin
      if (wr_en_c) mem[wr_bank_c][i_addr] <= i_data;
      if (issue_c) rd_word <= mem[iss_sel][iss_cnt[7:1]];
   end

   // State, bank flags and counters
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wstate        <= W_IDLE;
         wbank         <= 1'b0;
         exp_idx       <= 7'd0;
         wr_sel        <= 1'b0;
         rstate        <= R_IDLE;
         iss_cnt       <= 8'd0;
         iss_sel       <= 1'b0;
         rd_sel        <= 1'b0;
         o_bank_full   <= 2'b00;
         o_frm_err_cnt <= '0;
         o_ovf_cnt     <= '0;
      end else begin
         wstate  <= wstate_n;
         wbank   <= wbank_n;
         exp_idx <= exp_idx_n;
         rstate  <= rstate_n;
         iss_cnt <= iss_cnt_n;
         iss_sel <= iss_sel_n;
         if (commit_c) begin
            o_bank_full[wbank] <= 1'b1;
            wr_sel             <= ~wr_sel;
         end
         if (pop_c && o_eop) begin
            o_bank_full[rd_sel] <= 1'b0;
            rd_sel              <= ~rd_sel;
         end
         if (frm_err_c && o_frm_err_cnt != '1) o_frm_err_cnt <= o_frm_err_cnt + CNT_WIDTH'(1);
         if (ovf_c && o_ovf_cnt != '1)         o_ovf_cnt     <= o_ovf_cnt + CNT_WIDTH'(1);
      end
   end

   // Read pipeline and 2-entry output skid (output register + one spare)
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         p_v     <= 1'b0;
         p_idx   <= 8'd0;
         s_v     <= 1'b0;
         s_iq    <= '0;
         s_idx   <= 8'd0;
         o_valid <= 1'b0;
         o_iq    <= '0;
         o_idx   <= 8'd0;
         o_sop   <= 1'b0;
         o_eop   <= 1'b0;
      end else begin
         p_v   <= issue_c;
         p_idx <= iss_cnt;
         if (!o_valid || i_ready) begin
            if (s_v) begin
               o_valid <= 1'b1;
               o_iq    <= s_iq;
               o_idx   <= s_idx;
               o_sop   <= (s_idx == 8'd0);
               o_eop   <= (s_idx == LAST_SMP);
               s_v     <= p_v;
               s_iq    <= p_iq_c;
               s_idx   <= p_idx;
            end else begin
               o_valid <= p_v;
               o_sop   <= p_v && (p_idx == 8'd0);
               o_eop   <= p_v && (p_idx == LAST_SMP);
               if (p_v) begin
                  o_iq  <= p_iq_c;
                  o_idx <= p_idx;
               end
            end
         end else if (p_v) begin
            s_v   <= 1'b1;
            s_iq  <= p_iq_c;
            s_idx <= p_idx;
         end
      end
   end
endmodule

// File: tb/tb_cpri_chip_unpack.sv
// Self-checking bench for cpri_chip_unpack: directed chip table plus
// hand-written back-to-back, backpressure, reset and saturation sequences.
module tb_cpri_chip_unpack;
   typedef struct packed {
      logic [31:0] iq;
      logic [7:0]  idx;
   } smp_t;

   typedef struct {
      int          kind;
      logic [31:0] base;
      bit          out;
      int          d_frm;
      int          d_ovf;
   } vec_t;

   logic i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   logic        i_reset;
   logic [63:0] i_data;
   logic [6:0]  i_addr;
   logic        i_last, i_valid, i_ready, tgt_sat;
   logic        valid_main, valid_sat;

   logic [31:0] o_iq;
   logic [7:0]  o_idx;
   logic        o_sop, o_eop, o_valid;
   logic [1:0]  o_bank_full;
   logic [15:0] o_frm_err_cnt, o_ovf_cnt;

   logic [31:0] sat_iq;
   logic [7:0]  sat_idx;
   logic        sat_sop, sat_eop, sat_valid;
   logic [1:0]  sat_bank_full;
   logic [1:0]  sat_frm, sat_ovf;

   assign valid_main = i_valid & ~tgt_sat;
   assign valid_sat  = i_valid & tgt_sat;

   cpri_chip_unpack dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_addr(i_addr),
      .i_last(i_last), .i_valid(valid_main), .o_iq(o_iq), .o_idx(o_idx),
      .o_sop(o_sop), .o_eop(o_eop), .o_valid(o_valid), .i_ready(i_ready),
      .o_bank_full(o_bank_full), .o_frm_err_cnt(o_frm_err_cnt), .o_ovf_cnt(o_ovf_cnt)
   );

   cpri_chip_unpack #(.CNT_WIDTH(2)) dut_sat (
      .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_addr(i_addr),
      .i_last(i_last), .i_valid(valid_sat), .o_iq(sat_iq), .o_idx(sat_idx),
      .o_sop(sat_sop), .o_eop(sat_eop), .o_valid(sat_valid), .i_ready(1'b1),
      .o_bank_full(sat_bank_full), .o_frm_err_cnt(sat_frm), .o_ovf_cnt(sat_ovf)
   );

   int   n_cmp = 0;
   int   n_fail = 0;
   int   mdl_frm = 0;
   int   mdl_ovf = 0;
   bit   tog_en = 1'b0;
   bit   rst_hold = 1'b0;
   smp_t exp_q[$];
   vec_t vecs[6];

   bit          have_prev;
   bit          prev_v, prev_rdy;
   logic [7:0]  prev_idx;
   logic [31:0] prev_iq;
   smp_t        me;
   bit          found;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic put_word(input logic [6:0] a, input logic [31:0] base, input logic last);
      i_addr  = a;
      i_data  = {base + 32'(a) * 32'd2 + 32'd1, base + 32'(a) * 32'd2};
      i_last  = last;
      i_valid = 1'b1;
      @(posedge i_clk);
      #1;
   endtask

   // kind 0 clean, 1 word 40 missing, 2 no last on 95, 3 early last at 50,
   // 4 fill aborted at word 30 by a fresh word 0 followed by a clean chip
   task automatic send_chip(input int kind, input logic [31:0] base);
      case (kind)
         1: for (int a = 0; a < 96; a++) if (a != 40) put_word(7'(a), base, a == 95);
         2: for (int a = 0; a < 96; a++) put_word(7'(a), base, 1'b0);
         3: for (int a = 0; a <= 50; a++) put_word(7'(a), base, a == 50);
         4: begin
            for (int a = 0; a < 30; a++) put_word(7'(a), base + 32'h500, 1'b0);
            for (int a = 0; a < 96; a++) put_word(7'(a), base, a == 95);
         end
         default: for (int a = 0; a < 96; a++) put_word(7'(a), base, a == 95);
      endcase
      i_valid = 1'b0;
      i_last  = 1'b0;
   endtask

   task automatic push_exp(input logic [31:0] base);
      for (int s = 0; s < 192; s++) begin
         smp_t e;
         e.iq  = base + 32'(s);
         e.idx = 8'(s);
         exp_q.push_back(e);
      end
   endtask

   task automatic drain(input string name);
      int c = 0;
      while (exp_q.size() != 0 && c < 2000) begin
         @(posedge i_clk);
         c++;
      end
      check({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
      repeat (4) @(posedge i_clk);
      #1;
   endtask

   task automatic check_state(input string name);
      check({name, "_frm_cnt"}, 64'(o_frm_err_cnt), 64'(mdl_frm));
      check({name, "_ovf_cnt"}, 64'(o_ovf_cnt), 64'(mdl_ovf));
      check({name, "_bank_full"}, 64'(o_bank_full), 64'd0);
   endtask

   initial begin
      i_reset = 1'b1;
      i_data  = '0;
      i_addr  = '0;
      i_last  = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      tgt_sat = 1'b0;
      have_prev = 1'b0;

      fork
         // accepted-sample scoreboard, stall-hold and no-gap checks
         forever begin
            @(negedge i_clk);
            if (i_reset || rst_hold) begin
               have_prev = 1'b0;
            end else begin
               if (have_prev && prev_v && !prev_rdy)
                  check("stall_hold", {23'd0, o_valid, o_idx, o_iq}, {23'd0, 1'b1, prev_idx, prev_iq});
               if (have_prev && prev_v && prev_rdy && prev_idx != 8'd191)
                  check("mid_chip_valid", 64'(o_valid), 64'd1);
               if (o_valid && i_ready) begin
                  if (exp_q.size() == 0) begin
                     n_cmp++;
                     n_fail++;
                     $display("FAIL unexpected_sample: got idx %0d iq 0x%0h, required no sample",
                              o_idx, o_iq);
                  end else begin
                     me = exp_q.pop_front();
                     check("sample", {22'd0, o_iq, o_idx, o_sop, o_eop},
                           {22'd0, me.iq, me.idx, me.idx == 8'd0, me.idx == 8'd191});
                  end
               end
               have_prev = 1'b1;
               prev_v    = o_valid;
               prev_rdy  = i_ready;
               prev_idx  = o_idx;
               prev_iq   = o_iq;
            end
         end
         forever begin
            @(posedge i_clk);
            #1;
            i_ready = tog_en ? ~i_ready : 1'b1;
         end
         begin
            #3000000;
            $display("FAIL watchdog: simulation still running, required completion");
            $fatal(1);
         end
      join_none

      vecs[0] = '{1, 32'h2000, 1'b0, 1, 0};
      vecs[1] = '{0, 32'h3000, 1'b1, 0, 0};
      vecs[2] = '{2, 32'h4000, 1'b0, 1, 0};
      vecs[3] = '{3, 32'h5000, 1'b0, 1, 0};
      vecs[4] = '{4, 32'h6000, 1'b1, 1, 0};
      vecs[5] = '{0, 32'h7000, 1'b1, 0, 0};

      repeat (3) @(posedge i_clk);
      #1;
      check("reset_valid", 64'(o_valid), 64'd0);
      check("reset_iq_idx", {24'd0, o_iq, o_idx}, 64'd0);
      check("reset_sop_eop", {62'd0, o_sop, o_eop}, 64'd0);
      check_state("reset");
      i_reset = 1'b0;
      @(posedge i_clk);
      #1;

      // single chip with commit-to-output latency
      push_exp(32'h1000);
      send_chip(0, 32'h1000);
      @(negedge i_clk);
      check("commit_bank_full", 64'(o_bank_full), 64'd1);
      check("commit_valid_lat0", 64'(o_valid), 64'd0);
      @(negedge i_clk);
      check("commit_valid_lat1", 64'(o_valid), 64'd0);
      @(negedge i_clk);
      check("commit_valid_lat2", 64'(o_valid), 64'd1);
      drain("single");
      check_state("single");

      foreach (vecs[i]) begin
         if (vecs[i].out) push_exp(vecs[i].base);
         send_chip(vecs[i].kind, vecs[i].base);
         mdl_frm += vecs[i].d_frm;
         mdl_ovf += vecs[i].d_ovf;
         drain($sformatf("vec%0d", i));
         check_state($sformatf("vec%0d", i));
      end

      // three chips back-to-back: third finds both banks occupied
      push_exp(32'h8000);
      push_exp(32'h9000);
      send_chip(0, 32'h8000);
      send_chip(0, 32'h9000);
      check("b2b_both_full", 64'(o_bank_full), 64'd3);
      send_chip(0, 32'hF000);
      mdl_ovf++;
      drain("b2b");
      check_state("b2b");

      // readout with i_ready toggling every cycle
      tog_en = 1'b1;
      push_exp(32'h1800);
      send_chip(0, 32'h1800);
      drain("toggle");
      tog_en = 1'b0;
      check_state("toggle");

      // reset mid-readout with the second bank committed
      push_exp(32'hA000);
      push_exp(32'hB000);
      send_chip(0, 32'hA000);
      send_chip(0, 32'hB000);
      found = 1'b0;
      for (int c = 0; c < 1000 && !found; c++) begin
         @(negedge i_clk);
         if (o_valid && o_idx == 8'd100 && o_iq == 32'hA064) found = 1'b1;
      end
      check("reach_sample100", 64'(found), 64'd1);
      @(posedge i_clk);
      #1;
      rst_hold = 1'b1;
      i_reset  = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      check("midreset_valid", 64'(o_valid), 64'd0);
      check("midreset_bank_full", 64'(o_bank_full), 64'd0);
      check("midreset_ovf", 64'(o_ovf_cnt), 64'd0);
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      exp_q.delete();
      mdl_frm  = 0;
      mdl_ovf  = 0;
      rst_hold = 1'b0;
      push_exp(32'hC000);
      send_chip(0, 32'hC000);
      drain("post_reset");
      check_state("post_reset");

      // 2-bit counter saturation on the second instance
      tgt_sat = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         send_chip(1, 32'hD000);
         check($sformatf("sat_frm_%0d", n), 64'(sat_frm), 64'((n > 3) ? 3 : n));
      end
      check("sat_ovf", 64'(sat_ovf), 64'd0);
      check("sat_idle", {61'd0, sat_valid, sat_bank_full}, 64'd0);
      tgt_sat = 1'b0;
      check("main_untouched_frm", 64'(o_frm_err_cnt), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
